spi_link_engine: RTL and testbench
==================================

SPI_LINK_ENGINE -- requirements
Module: spi_link_engine

Interface
REQ-001 SHALL have parameter NUM_CH, default 4 (legal 1..16), giving the number of FIFO channels.
REQ-002 SHALL have parameter REG_AW, default 7, giving the register address width.
REQ-003 SHALL have parameter FILL, default 8'h00, giving the byte returned on a read from an empty FIFO.
REQ-004 Ports SHALL be (clk and rst first):
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received SPI byte.
- rx_valid  in  1  one-cycle strobe qualifying rx_data; consecutive strobes are at least 3 cycles apart.
- frame_end  in  1  one-cycle strobe at chip-select deassert.
- tx_data  out  8  byte to load into the SPI shifter.
- tx_valid  out  1  one-cycle strobe qualifying tx_data.
- reg_addr  out  REG_AW  register address.
- reg_wdata  out  8  register write data.
- reg_we  out  1  register write strobe.
- reg_re  out  1  register read strobe.
- reg_rdata  in  8  register read data, valid 1 cycle after reg_re.
- fifo_wdata  out  8  FIFO write data, shared by all channels.
- fifo_we  out  NUM_CH  per-channel write strobe.
- fifo_full  in  NUM_CH  per-channel full flag.
- fifo_re  out  NUM_CH  per-channel pop strobe.
- fifo_rdata  in  8*NUM_CH  channel c occupies bits [8c+7:8c]; valid 1 cycle after fifo_re.
- fifo_empty  in  NUM_CH  per-channel empty flag.
- status  out  8  sticky error flags.

Function
REQ-005 The first byte after IDLE SHALL be the opcode: bits [7:4] are the command, bits [3:0] are the channel ch.
REQ-006 Command 0x1 (REG_WR) SHALL take an address byte and then a data byte.
- On the data byte: reg_we pulses 1 cycle, with reg_addr = addr[REG_AW-1:0] and reg_wdata = data.
- Then return to IDLE.
REQ-007 Command 0x2 (REG_RD) SHALL take an address byte, accepted at cycle N.
- Cycle N+1: reg_re = 1 with reg_addr driven.
- Cycle N+2: tx_valid = 1 and tx_data = reg_rdata.
- Then return to IDLE.
REQ-008 Commands 0x3 (FIFO_WR) and 0x4 (FIFO_RD) SHALL take LEN_LO, then LEN_HI, then a body of {LEN_HI,LEN_LO}+1 bytes (1..65536).
REQ-009 FIFO_WR body byte: if fifo_full[ch] = 0, fifo_we[ch] pulses 1 cycle after the byte with fifo_wdata = byte; otherwise the byte is dropped and status[6] is set.
REQ-010 FIFO_RD body byte (content ignored) at cycle N:
- If fifo_empty[ch] = 0: fifo_re[ch] pulses at N+1, then at N+2 tx_valid = 1 and tx_data = channel ch data.
- If fifo_empty[ch] = 1: no pop; at N+2 tx_valid = 1, tx_data = FILL, and status[5] is set.
REQ-011 Command 0x5 (STATUS) SHALL, at opcode cycle N, return tx_valid = 1 with tx_data = status at N+2, clear status at N+2, and return to IDLE.
REQ-012 Any other command, or ch >= NUM_CH for commands 0x3/0x4, SHALL set status[7] and remain in IDLE; the channel field SHALL be ignored for commands 0x1, 0x2 and 0x5.
REQ-013 status SHALL be {err_cmd, err_ovf, err_udf, 5'b0}; if a set and a clear occur in the same cycle, the set wins.
REQ-014 States SHALL be IDLE, ADDR, REG_DATA, LEN_LO, LEN_HI, WR_BODY, RD_BODY; the body counter SHALL be 16 bits and return to IDLE after the final body byte.
REQ-015 frame_end in any state SHALL force IDLE on the next cycle.
- A coincident rx_valid byte is discarded.
- Strobes already scheduled still complete.
- No further strobes are issued.
REQ-016 All strobes (reg_we, reg_re, fifo_we, fifo_re, tx_valid) SHALL be exactly 1 cycle wide, and at most one fifo_we/fifo_re bit SHALL be high at any time.

Reset
REQ-017 rst SHALL take priority over all other inputs; a reset mid-burst SHALL abandon the burst.
REQ-018 During reset: state = IDLE, all strobes = 0, status = 0, tx_data = 0, reg_addr = 0, reg_wdata = 0, fifo_wdata = 0, body counter = 0.

Verification
REQ-019 Bytes 0x10, 0x05, 0xA5 -> single reg_we, reg_addr = 5, reg_wdata = 0xA5, then IDLE.
REQ-020 Bytes 0x22, 0x7F with reg_rdata = 0x3C -> reg_re 1 cycle after the address byte, then tx_valid with tx_data = 0x3C one cycle later.
REQ-021 Bytes 0x31, 0x02, 0x00, D0, D1, D2 with ch1 not full -> three fifo_we[1] pulses carrying D0..D2; fifo_we[0], [2] and [3] stay 0.
REQ-022 Bytes 0x40, 0x01, 0x00, x, x with ch0 holding 1 entry (0x55) -> first tx = 0x55 with one fifo_re[0]; second tx = 0x00 with no pop; then STATUS (0x50) returns 0x20 and a second STATUS returns 0x00.
REQ-023 Bytes 0x36 with NUM_CH = 4 -> no strobes, status[7] = 1; a FIFO_WR to a full channel sets status[6].
REQ-024 A FIFO_WR of length 0x0003 with frame_end after 2 body bytes -> exactly 2 fifo_we pulses, IDLE, and the next opcode is decoded correctly; rst asserted mid-burst -> all outputs at reset values.

Source files
------------

// File: rtl/spi_link_engine.sv
// Byte-level command engine behind an SPI slave: decodes opcodes into register
// accesses and per-channel FIFO bursts, and returns read data through tx_data/tx_valid.
module spi_link_engine #(
  parameter int          NUM_CH = 4,
  parameter int          REG_AW = 7,
  parameter logic [7:0]  FILL   = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  frame_end,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  output logic [REG_AW-1:0]     reg_addr,
  output logic [7:0]            reg_wdata,
  output logic                  reg_we,
  output logic                  reg_re,
  input  logic [7:0]            reg_rdata,
  output logic [7:0]            fifo_wdata,
  output logic [NUM_CH-1:0]     fifo_we,
  input  logic [NUM_CH-1:0]     fifo_full,
  output logic [NUM_CH-1:0]     fifo_re,
  input  logic [8*NUM_CH-1:0]   fifo_rdata,
  input  logic [NUM_CH-1:0]     fifo_empty,
  output logic [7:0]            status
);

  localparam logic [3:0] CMD_REG_WR  = 4'h1;
  localparam logic [3:0] CMD_REG_RD  = 4'h2;
  localparam logic [3:0] CMD_FIFO_WR = 4'h3;
  localparam logic [3:0] CMD_FIFO_RD = 4'h4;
  localparam logic [3:0] CMD_STATUS  = 4'h5;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_REG_DATA, S_LEN_LO, S_LEN_HI, S_WR_BODY, S_RD_BODY
  } state_e;

  // Where the byte presented on tx_data comes from, two cycles after the request.
  typedef enum logic [2:0] {
    TX_NONE, TX_REG, TX_FIFO, TX_FILL, TX_STAT
  } tx_src_e;

  state_e              state_q, state_d;
  logic                is_rd_q, is_rd_d;
  logic [3:0]          ch_q, ch_d;
  logic [7:0]          len_lo_q, len_lo_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [REG_AW-1:0]   reg_addr_q, reg_addr_d;
  logic [7:0]          reg_wdata_q, reg_wdata_d;
  logic                reg_we_q, reg_we_d;
  logic                reg_re_q, reg_re_d;
  logic [7:0]          fifo_wdata_q, fifo_wdata_d;
  logic [NUM_CH-1:0]   fifo_we_q, fifo_we_d;
  logic [NUM_CH-1:0]   fifo_re_q, fifo_re_d;
  tx_src_e             pend_q, pend_d;
  tx_src_e             tx_src_q, tx_src_d;
  logic                err_cmd_q, err_cmd_d;
  logic                err_ovf_q, err_ovf_d;
  logic                err_udf_q, err_udf_d;

  logic [NUM_CH-1:0]   ch_onehot;
  logic [7:0]          fifo_byte;
  logic                full_sel, empty_sel, byte_in, body_last;
  logic                set_cmd, set_ovf, set_udf, clr_status;

  always_comb begin
    ch_onehot = '0;
    fifo_byte = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_q == 4'(c)) begin
        ch_onehot[c] = 1'b1;
        fifo_byte    = fifo_rdata[8*c +: 8];
      end
    end
  end

  assign full_sel  = |(fifo_full & ch_onehot);
  assign empty_sel = |(fifo_empty & ch_onehot);
  assign byte_in   = rx_valid && !frame_end;
  assign body_last = (cnt_q == 16'd0);

  // NOTE: every combinational output gets a default before the case so no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    is_rd_d      = is_rd_q;
    ch_d         = ch_q;
    len_lo_d     = len_lo_q;
    cnt_d        = cnt_q;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;
    fifo_wdata_d = fifo_wdata_q;
    reg_we_d     = 1'b0;
    reg_re_d     = 1'b0;
    fifo_we_d    = '0;
    fifo_re_d    = '0;
    pend_d       = TX_NONE;
    set_cmd      = 1'b0;
    set_ovf      = 1'b0;

    if (byte_in) begin
      unique case (state_q)
        S_IDLE: begin
          unique case (rx_data[7:4])
            CMD_REG_WR, CMD_REG_RD: begin
              is_rd_d = (rx_data[7:4] == CMD_REG_RD);
              state_d = S_ADDR;
            end
            CMD_FIFO_WR, CMD_FIFO_RD: begin
              if (int'(rx_data[3:0]) >= NUM_CH) begin
                set_cmd = 1'b1;
              end else begin
                is_rd_d = (rx_data[7:4] == CMD_FIFO_RD);
                ch_d    = rx_data[3:0];
                state_d = S_LEN_LO;
              end
            end
            CMD_STATUS: pend_d  = TX_STAT;
            default:    set_cmd = 1'b1;
          endcase
        end
        S_ADDR: begin
          reg_addr_d = REG_AW'(rx_data);
          if (is_rd_q) begin
            reg_re_d = 1'b1;
            pend_d   = TX_REG;
            state_d  = S_IDLE;
          end else begin
            state_d = S_REG_DATA;
          end
        end
        S_REG_DATA: begin
          reg_wdata_d = rx_data;
          reg_we_d    = 1'b1;
          state_d     = S_IDLE;
        end
        S_LEN_LO: begin
          len_lo_d = rx_data;
          state_d  = S_LEN_HI;
        end
        S_LEN_HI: begin
          cnt_d   = {rx_data, len_lo_q};
          state_d = is_rd_q ? S_RD_BODY : S_WR_BODY;
        end
        S_WR_BODY, S_RD_BODY: begin
          if (state_q == S_WR_BODY) begin
            if (full_sel) begin
              set_ovf = 1'b1;
            end else begin
              fifo_we_d    = ch_onehot;
              fifo_wdata_d = rx_data;
            end
          end else if (empty_sel) begin
            pend_d = TX_FILL;
          end else begin
            fifo_re_d = ch_onehot;
            pend_d    = TX_FIFO;
          end
          if (body_last) state_d = S_IDLE;
          else           cnt_d   = cnt_q - 16'd1;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Ends the frame for new bytes; requests already in the pipeline still finish.
    if (frame_end) state_d = S_IDLE;
  end

  assign set_udf    = (pend_q == TX_FILL);
  assign clr_status = (tx_src_q == TX_STAT);
  assign tx_src_d   = pend_q;
  assign err_cmd_d  = set_cmd | (err_cmd_q & ~clr_status);
  assign err_ovf_d  = set_ovf | (err_ovf_q & ~clr_status);
  assign err_udf_d  = set_udf | (err_udf_q & ~clr_status);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      is_rd_q      <= 1'b0;
      ch_q         <= '0;
      len_lo_q     <= '0;
      cnt_q        <= '0;
      reg_addr_q   <= '0;
      reg_wdata_q  <= '0;
      reg_we_q     <= 1'b0;
      reg_re_q     <= 1'b0;
      fifo_wdata_q <= '0;
      fifo_we_q    <= '0;
      fifo_re_q    <= '0;
      pend_q       <= TX_NONE;
      tx_src_q     <= TX_NONE;
      err_cmd_q    <= 1'b0;
      err_ovf_q    <= 1'b0;
      err_udf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_rd_q      <= is_rd_d;
      ch_q         <= ch_d;
      len_lo_q     <= len_lo_d;
      cnt_q        <= cnt_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
      reg_we_q     <= reg_we_d;
      reg_re_q     <= reg_re_d;
      fifo_wdata_q <= fifo_wdata_d;
      fifo_we_q    <= fifo_we_d;
      fifo_re_q    <= fifo_re_d;
      pend_q       <= pend_d;
      tx_src_q     <= tx_src_d;
      err_cmd_q    <= err_cmd_d;
      err_ovf_q    <= err_ovf_d;
      err_udf_q    <= err_udf_d;
    end
  end

  // Read data arrives one cycle after the strobe, so tx_data is muxed live.
  always_comb begin
    tx_data = 8'h00;
    unique case (tx_src_q)
      TX_REG:  tx_data = reg_rdata;
      TX_FIFO: tx_data = fifo_byte;
      TX_FILL: tx_data = FILL;
      TX_STAT: tx_data = status;
      default: tx_data = 8'h00;
    endcase
  end

  assign tx_valid   = (tx_src_q != TX_NONE);
  assign reg_addr   = reg_addr_q;
  assign reg_wdata  = reg_wdata_q;
  assign reg_we     = reg_we_q;
  assign reg_re     = reg_re_q;
  assign fifo_wdata = fifo_wdata_q;
  assign fifo_we    = fifo_we_q;
  assign fifo_re    = fifo_re_q;
  assign status     = {err_cmd_q, err_ovf_q, err_udf_q, 5'b0};

endmodule

// File: tb/tb_spi_link_engine.sv
// Directed bench for spi_link_engine: a table of register transactions plus
// hand-written FIFO, error, frame_end and reset sequences.
module tb_spi_link_engine;

  localparam int NC = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            frame_end;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic [6:0]      reg_addr;
  logic [7:0]      reg_wdata;
  logic            reg_we;
  logic            reg_re;
  logic [7:0]      reg_rdata;
  logic [7:0]      fifo_wdata;
  logic [NC-1:0]   fifo_we;
  logic [NC-1:0]   fifo_full;
  logic [NC-1:0]   fifo_re;
  logic [8*NC-1:0] fifo_rdata;
  logic [NC-1:0]   fifo_empty;
  logic [7:0]      status;

  spi_link_engine dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_end(frame_end), .tx_data(tx_data), .tx_valid(tx_valid),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_re(reg_re), .reg_rdata(reg_rdata), .fifo_wdata(fifo_wdata),
    .fifo_we(fifo_we), .fifo_full(fifo_full), .fifo_re(fifo_re),
    .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty), .status(status)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: strobe counts, FIFO write log, one-hot and pulse-width violations.
  typedef struct { logic [NC-1:0] we; logic [7:0] d; } fwe_t;
  fwe_t fwe_q[$];
  int n_reg_we = 0, n_reg_re = 0, n_fre = 0, n_tx = 0, viol = 0;
  logic p_we = 0, p_re = 0, p_tx = 0;
  logic [NC-1:0] p_fwe = '0, p_fre = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if ($countones(fifo_we) > 1 || $countones(fifo_re) > 1) viol++;
      if ((reg_we && p_we) || (reg_re && p_re) || (tx_valid && p_tx) ||
          ((fifo_we & p_fwe) != '0) || ((fifo_re & p_fre) != '0)) viol++;
      if (reg_we) n_reg_we++;
      if (reg_re) n_reg_re++;
      if (fifo_re != '0) n_fre++;
      if (tx_valid) n_tx++;
      if (fifo_we != '0) fwe_q.push_back('{we: fifo_we, d: fifo_wdata});
    end
    p_we = reg_we; p_re = reg_re; p_tx = tx_valid; p_fwe = fifo_we; p_fre = fifo_re;
  end

  // Present one byte; returns #1 into the cycle after the byte.
  task automatic drive(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    drive(b);
    idle(3);
  endtask

  typedef struct {
    bit         is_rd;
    logic [7:0] op;
    logic [7:0] addr;
    logic [7:0] data;
    logic [6:0] exp_addr;
  } reg_vec_t;

  reg_vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int we0, re0, tot0, tot1, fre0;
    logic [7:0] wr_exp[3];

    vecs[0] = '{is_rd: 0, op: 8'h10, addr: 8'h05, data: 8'hA5, exp_addr: 7'h05};
    vecs[1] = '{is_rd: 1, op: 8'h22, addr: 8'h7F, data: 8'h3C, exp_addr: 7'h7F};
    vecs[2] = '{is_rd: 0, op: 8'h1F, addr: 8'hFF, data: 8'h00, exp_addr: 7'h7F};
    vecs[3] = '{is_rd: 1, op: 8'h2A, addr: 8'h80, data: 8'hC3, exp_addr: 7'h00};
    vecs[4] = '{is_rd: 0, op: 8'h13, addr: 8'h2A, data: 8'h5A, exp_addr: 7'h2A};

    rst = 1'b1; rx_data = '0; rx_valid = 1'b0; frame_end = 1'b0; reg_rdata = '0;
    fifo_full = '0; fifo_empty = '1; fifo_rdata = {8'hD3, 8'hC2, 8'hB1, 8'h55};
    idle(3);
    check("reset strobes", {28'd0, tx_valid, reg_we, reg_re, |fifo_we}, 32'd0);
    check("reset fifo_re", {28'd0, fifo_re}, 32'd0);
    check("reset data", {8'd0, tx_data, reg_wdata, fifo_wdata}, 32'd0);
    check("reset reg_addr", {25'd0, reg_addr}, 32'd0);
    check("reset status", {24'd0, status}, 32'd0);
    rst = 1'b0;
    idle(2);

    // Register transactions from the table.
    for (int i = 0; i < 5; i++) begin
      we0 = n_reg_we; re0 = n_reg_re;
      send(vecs[i].op);
      if (!vecs[i].is_rd) begin
        send(vecs[i].addr);
        drive(vecs[i].data);
        check($sformatf("v%0d reg_we", i), {31'd0, reg_we}, 32'd1);
        check($sformatf("v%0d reg_addr", i), {25'd0, reg_addr}, {25'd0, vecs[i].exp_addr});
        check($sformatf("v%0d reg_wdata", i), {24'd0, reg_wdata}, {24'd0, vecs[i].data});
        idle(1);
        check($sformatf("v%0d reg_we width", i), {31'd0, reg_we}, 32'd0);
      end else begin
        reg_rdata = vecs[i].data;
        drive(vecs[i].addr);
        check($sformatf("v%0d reg_re", i), {31'd0, reg_re}, 32'd1);
        check($sformatf("v%0d reg_addr", i), {25'd0, reg_addr}, {25'd0, vecs[i].exp_addr});
        idle(1);
        check($sformatf("v%0d tx_valid", i), {31'd0, tx_valid}, 32'd1);
        check($sformatf("v%0d tx_data", i), {24'd0, tx_data}, {24'd0, vecs[i].data});
        check($sformatf("v%0d reg_re width", i), {31'd0, reg_re}, 32'd0);
        idle(1);
        check($sformatf("v%0d tx width", i), {31'd0, tx_valid}, 32'd0);
      end
      idle(3);
      check($sformatf("v%0d reg_we count", i), n_reg_we - we0, vecs[i].is_rd ? 0 : 1);
      check($sformatf("v%0d reg_re count", i), n_reg_re - re0, vecs[i].is_rd ? 1 : 0);
    end

    // FIFO_WR of three bytes to channel 1.
    wr_exp = '{8'h11, 8'h22, 8'h33};
    fwe_q.delete();
    send(8'h31); send(8'h02); send(8'h00);
    send(wr_exp[0]); send(wr_exp[1]);
    drive(wr_exp[2]);
    check("fwr timing we", {28'd0, fifo_we}, 32'h2);
    check("fwr timing data", {24'd0, fifo_wdata}, 32'h33);
    idle(4);
    check("fwr pulse count", fwe_q.size(), 3);
    for (int k = 0; k < 3 && k < fwe_q.size(); k++) begin
      check($sformatf("fwr%0d we", k), {28'd0, fwe_q[k].we}, 32'h2);
      check($sformatf("fwr%0d data", k), {24'd0, fwe_q[k].d}, {24'd0, wr_exp[k]});
    end

    // FIFO_RD of two bytes from channel 0 holding a single 0x55.
    fifo_empty = 4'b1110;
    fre0 = n_fre;
    send(8'h40); send(8'h01); send(8'h00);
    drive(8'hAA);
    check("frd0 fifo_re", {28'd0, fifo_re}, 32'h1);
    fifo_empty[0] = 1'b1;
    idle(1);
    check("frd0 tx_valid", {31'd0, tx_valid}, 32'd1);
    check("frd0 tx_data", {24'd0, tx_data}, 32'h55);
    check("frd0 status", {24'd0, status}, 32'h00);
    idle(2);
    drive(8'hBB);
    check("frd1 no pop", {28'd0, fifo_re}, 32'h0);
    idle(1);
    check("frd1 tx_valid", {31'd0, tx_valid}, 32'd1);
    check("frd1 fill", {24'd0, tx_data}, 32'h00);
    check("frd1 status udf", {24'd0, status}, 32'h20);
    idle(2);
    check("frd pop count", n_fre - fre0, 1);
    drive(8'h50);
    idle(1);
    check("stat1 tx_valid", {31'd0, tx_valid}, 32'd1);
    check("stat1 tx_data", {24'd0, tx_data}, 32'h20);
    idle(1);
    check("stat1 cleared", {24'd0, status}, 32'h00);
    idle(2);
    drive(8'h50);
    idle(1);
    check("stat2 tx", {23'd0, tx_valid, tx_data}, 32'h100);
    idle(3);

    // Illegal channel and unknown command.
    tot0 = n_reg_we + n_reg_re + n_tx + n_fre + fwe_q.size();
    drive(8'h36);
    check("bad ch status", {24'd0, status}, 32'h80);
    idle(3);
    tot1 = n_reg_we + n_reg_re + n_tx + n_fre + fwe_q.size();
    check("bad ch no strobes", tot1 - tot0, 0);
    drive(8'h50);
    idle(1);
    check("stat err_cmd", {24'd0, tx_data}, 32'h80);
    idle(3);
    drive(8'h70);
    check("bad cmd status", {24'd0, status}, 32'h80);
    idle(3);
    send(8'h50);

    // FIFO_WR to a full channel drops the byte; next byte lands once not full.
    fifo_full = 4'b0100;
    fwe_q.delete();
    send(8'h32); send(8'h01); send(8'h00);
    drive(8'h99);
    check("full no we", {28'd0, fifo_we}, 32'h0);
    check("full status ovf", {24'd0, status}, 32'h40);
    idle(3);
    fifo_full = '0;
    drive(8'h9A);
    check("after full we", {28'd0, fifo_we}, 32'h4);
    check("after full data", {24'd0, fifo_wdata}, 32'h9A);
    idle(3);
    check("full burst count", fwe_q.size(), 1);
    drive(8'h50);
    idle(1);
    check("stat err_ovf", {24'd0, tx_data}, 32'h40);
    idle(3);

    // frame_end after two of three body bytes, then a fresh REG_WR.
    fwe_q.delete();
    send(8'h33); send(8'h02); send(8'h00);
    send(8'hD0); send(8'hD1);
    @(posedge clk); #1 frame_end = 1'b1;
    @(posedge clk); #1 frame_end = 1'b0;
    idle(2);
    send(8'h10); send(8'h09);
    drive(8'h77);
    check("fe next reg_we", {31'd0, reg_we}, 32'd1);
    check("fe next reg_addr", {25'd0, reg_addr}, 32'h09);
    idle(3);
    check("fe fifo_we count", fwe_q.size(), 2);
    if (fwe_q.size() == 2) begin
      check("fe pulse0", {20'd0, fwe_q[0].we, fwe_q[0].d}, {20'd0, 4'h8, 8'hD0});
      check("fe pulse1", {20'd0, fwe_q[1].we, fwe_q[1].d}, {20'd0, 4'h8, 8'hD1});
    end

    // A byte coincident with frame_end is discarded.
    fwe_q.delete();
    send(8'h30); send(8'h05); send(8'h00); send(8'h01);
    @(posedge clk); #1 rx_data = 8'h02; rx_valid = 1'b1; frame_end = 1'b1;
    @(posedge clk); #1 rx_valid = 1'b0; frame_end = 1'b0;
    check("fe coincident no we", {28'd0, fifo_we}, 32'h0);
    idle(3);
    check("fe coincident count", fwe_q.size(), 1);
    drive(8'h50);
    idle(1);
    check("fe then status", {31'd0, tx_valid}, 32'd1);
    idle(3);

    // A register read already scheduled completes across frame_end.
    reg_rdata = 8'h5E;
    send(8'h20);
    drive(8'h44);
    frame_end = 1'b1;
    check("fe sched reg_re", {31'd0, reg_re}, 32'd1);
    idle(1);
    frame_end = 1'b0;
    check("fe sched tx", {23'd0, tx_valid, tx_data}, 32'h15E);
    idle(3);

    // Reset in the middle of a FIFO_WR burst.
    send(8'h30); send(8'h03); send(8'h00);
    drive(8'h42);
    check("pre-rst we", {20'd0, fifo_we, fifo_wdata}, {20'd0, 4'h1, 8'h42});
    rst = 1'b1;
    idle(1);
    check("rst strobes", {24'd0, tx_valid, reg_we, reg_re, fifo_we, |fifo_re}, 32'd0);
    check("rst data", {tx_data, reg_wdata, fifo_wdata, status}, 32'd0);
    check("rst reg_addr", {25'd0, reg_addr}, 32'd0);
    rst = 1'b0;
    idle(2);
    send(8'h10); send(8'h03);
    drive(8'h44);
    check("post-rst decode", {20'd0, reg_we, reg_addr, fifo_we}, {20'd0, 1'b1, 7'h03, 4'h0});
    idle(3);

    check("one-hot/width violations", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
